// File: rtl/router_fsm.sv
// Packet router control FSM: header decode, payload/parity load, full and wait handling.
// Optional WAIT_TILL_EMPTY timeout is enabled by defining ROUTER_FSM_WAIT_TIMEOUT_EN.
module router_fsm (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       fifo_full,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    StDecodeAddress,
    StLoadFirstData,
    StLoadData,
    StFifoFull,
    StLoadAfterFull,
    StLoadParity,
    StCheckParityError,
    StWaitTillEmpty
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;

  logic       hdr_empty;
  logic       addr_empty;
  logic       addr_soft_reset;

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  localparam logic [4:0] WaitLimit = 5'd29;
  logic [4:0] wait_cnt_q, wait_cnt_d;
`endif

  // Empty flag of the FIFO named by the incoming header (address 3 has none).
  always_comb begin
    hdr_empty = 1'b0;
    unique case (data_in)
      2'd0:    hdr_empty = fifo_empty_0;
      2'd1:    hdr_empty = fifo_empty_1;
      2'd2:    hdr_empty = fifo_empty_2;
      default: hdr_empty = 1'b0;
    endcase
  end

  // Status of the FIFO named by the latched address.
  always_comb begin
    addr_empty      = 1'b0;
    addr_soft_reset = 1'b0;
    unique case (addr_q)
      2'd0: begin
        addr_empty      = fifo_empty_0;
        addr_soft_reset = soft_reset_0;
      end
      2'd1: begin
        addr_empty      = fifo_empty_1;
        addr_soft_reset = soft_reset_1;
      end
      2'd2: begin
        addr_empty      = fifo_empty_2;
        addr_soft_reset = soft_reset_2;
      end
      default: begin
        addr_empty      = 1'b0;
        addr_soft_reset = 1'b0;
      end
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    if (state_q == StDecodeAddress && pkt_valid) begin
      addr_d = data_in;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StDecodeAddress: begin
        if (pkt_valid && data_in != 2'd3) begin
          state_d = hdr_empty ? StLoadFirstData : StWaitTillEmpty;
        end
      end
      StLoadFirstData: state_d = StLoadData;
      StLoadData: begin
        if (fifo_full) begin
          state_d = StFifoFull;
        end else if (!pkt_valid) begin
          state_d = StLoadParity;
        end
      end
      StFifoFull: begin
        if (!fifo_full) begin
          state_d = StLoadAfterFull;
        end
      end
      StLoadAfterFull: begin
        if (parity_done) begin
          state_d = StDecodeAddress;
        end else if (low_pkt_valid) begin
          state_d = StLoadParity;
        end else begin
          state_d = StLoadData;
        end
      end
      StLoadParity: state_d = StCheckParityError;
      StCheckParityError: begin
        state_d = fifo_full ? StFifoFull : StDecodeAddress;
      end
      StWaitTillEmpty: begin
        if (addr_empty) begin
          state_d = StLoadFirstData;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
        end else if (wait_cnt_q == WaitLimit) begin
          state_d = StDecodeAddress;
`endif
        end
      end
      default: state_d = StDecodeAddress;
    endcase

    // Timeout of the addressed output aborts the packet from any busy state.
    if (state_q != StDecodeAddress && addr_soft_reset) begin
      state_d = StDecodeAddress;
    end
  end

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  // Held at zero outside WAIT_TILL_EMPTY, so it starts from zero on every entry.
  always_comb begin
    wait_cnt_d = '0;
    if (state_q == StWaitTillEmpty) begin
      wait_cnt_d = wait_cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StDecodeAddress;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b1;
    unique case (state_q)
      StDecodeAddress: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
      StLoadFirstData: lfd_state = 1'b1;
      StLoadData: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
      end
      StFifoFull: full_state = 1'b1;
      StLoadAfterFull: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      StLoadParity: write_enb_reg = 1'b1;
      StCheckParityError: rst_int_reg = 1'b1;
      StWaitTillEmpty: ;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed and random checks of router_fsm against a phase-level reference model.
module tb_router_fsm;

  logic clock = 1'b0;
  logic reset;
  logic pkt_valid;
  logic [1:0] data_in;
  logic fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic soft_reset_0, soft_reset_1, soft_reset_2;
  logic fifo_full, parity_done, low_pkt_valid;
  logic detect_add, lfd_state, ld_state, laf_state, full_state;
  logic write_enb_reg, rst_int_reg, busy;

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  router_fsm dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .fifo_full(fifo_full), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  // Reference model: packet phase, destination, cycles spent waiting.
  localparam int PDecode = 0, PFirst = 1, PLoad = 2, PFull = 3;
  localparam int PAfterFull = 4, PParity = 5, PCheck = 6, PWait = 7;
  int m_phase = PDecode;
  int m_dest = 0;
  int m_waited = 0;

  function automatic bit empty_of(input int d);
    return (d == 0) ? fifo_empty_0 : (d == 1) ? fifo_empty_1 : (d == 2) ? fifo_empty_2 : 1'b0;
  endfunction

  function automatic bit soft_of(input int d);
    return (d == 0) ? soft_reset_0 : (d == 1) ? soft_reset_1 : (d == 2) ? soft_reset_2 : 1'b0;
  endfunction

  task automatic model_clock();
    int nxt;
    int hdr;
    bit timeout_en;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    timeout_en = 1'b1;
`else
    timeout_en = 1'b0;
`endif
    hdr = int'(data_in);
    if (reset) begin
      m_phase = PDecode; m_dest = 0; m_waited = 0;
      return;
    end
    nxt = m_phase;
    case (m_phase)
      PDecode:    if (pkt_valid && hdr < 3) nxt = empty_of(hdr) ? PFirst : PWait;
      PFirst:     nxt = PLoad;
      PLoad:      nxt = fifo_full ? PFull : (!pkt_valid ? PParity : PLoad);
      PFull:      nxt = fifo_full ? PFull : PAfterFull;
      PAfterFull: nxt = parity_done ? PDecode : (low_pkt_valid ? PParity : PLoad);
      PParity:    nxt = PCheck;
      PCheck:     nxt = fifo_full ? PFull : PDecode;
      PWait: begin
        if (empty_of(m_dest)) nxt = PFirst;
        else if (timeout_en && m_waited + 1 == 30) nxt = PDecode;
      end
      default:    nxt = PDecode;
    endcase
    if (m_phase != PDecode && soft_of(m_dest)) nxt = PDecode;
    m_waited = (m_phase == PWait) ? m_waited + 1 : 0;
    if (m_phase == PDecode && pkt_valid) m_dest = hdr;
    m_phase = nxt;
  endtask

  // {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
  function automatic logic [7:0] expected_outs(input int p);
    logic [7:0] v;
    v = 8'b0000_0001;
    case (p)
      PDecode:    v = 8'b1000_0000;
      PFirst:     v = 8'b0100_0001;
      PLoad:      v = 8'b0010_0100;
      PFull:      v = 8'b0000_1001;
      PAfterFull: v = 8'b0001_0101;
      PParity:    v = 8'b0000_0101;
      PCheck:     v = 8'b0000_0011;
      default:    v = 8'b0000_0001;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] observed_outs();
    return {detect_add, lfd_state, ld_state, laf_state, full_state,
            write_enb_reg, rst_int_reg, busy};
  endfunction

  task automatic check_outs(input string tag);
    logic [7:0] obs, exp;
    obs = observed_outs();
    exp = expected_outs(m_phase);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    model_clock();
    #1;
    check_outs(tag);
  endtask

  task automatic idle_inputs();
    pkt_valid = 0; data_in = 0;
    fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
    soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
    fifo_full = 0; parity_done = 0; low_pkt_valid = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    step("reset0");
    step("reset1");
    check_bit("reset_detect_add", detect_add, 1'b1);
    check_bit("reset_busy", busy, 1'b0);
    reset = 0;

    // Header to port 2 with empty FIFO, payload, then parity
    pkt_valid = 1; data_in = 2; fifo_empty_2 = 1;
    step("hdr2_lfd");
    check_bit("hdr2_lfd_state", lfd_state, 1'b1);
    check_bit("hdr2_lfd_busy", busy, 1'b1);
    data_in = 1;
    step("hdr2_ld");
    check_bit("hdr2_ld_wen", write_enb_reg, 1'b1);
    check_bit("hdr2_ld_busy", busy, 1'b0);
    pkt_valid = 0;
    step("parity_load");
    check_bit("parity_wen", write_enb_reg, 1'b1);
    step("parity_check");
    check_bit("parity_rst_int", rst_int_reg, 1'b1);
    step("parity_back_decode");
    check_bit("parity_detect_add", detect_add, 1'b1);

    // FIFO full for three cycles, then release with low_pkt_valid
    pkt_valid = 1; data_in = 0;
    step("full_lfd");
    step("full_ld");
    fifo_full = 1;
    for (int i = 0; i < 3; i++) begin
      step("full_hold");
      check_bit("full_state_hold", full_state, 1'b1);
      check_bit("full_wen_low", write_enb_reg, 1'b0);
    end
    fifo_full = 0; low_pkt_valid = 1; pkt_valid = 0;
    step("after_full");
    check_bit("laf_state", laf_state, 1'b1);
    step("after_full_parity");
    low_pkt_valid = 0;
    step("after_full_check");
    step("after_full_decode");

    // Wait on port 1, foreign soft reset ignored, own soft reset aborts
    pkt_valid = 1; data_in = 1; fifo_empty_1 = 0;
    step("wait_enter");
    pkt_valid = 0; soft_reset_0 = 1;
    step("wait_foreign_soft");
    check_bit("wait_foreign_busy", busy, 1'b1);
    soft_reset_0 = 0; soft_reset_1 = 1;
    step("wait_own_soft");
    check_bit("wait_own_detect", detect_add, 1'b1);
    soft_reset_1 = 0; fifo_empty_1 = 1;

    // Invalid header 3 ignored
    pkt_valid = 1; data_in = 3;
    for (int i = 0; i < 5; i++) begin
      step("hdr3_ignored");
      check_bit("hdr3_wen", write_enb_reg, 1'b0);
    end

    // Wait timeout behaviour on port 0
    data_in = 0; fifo_empty_0 = 0;
    step("tmo_enter");
    pkt_valid = 0;
    for (int i = 1; i < 30; i++) step("tmo_waiting");
    step("tmo_cycle30");
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    check_bit("tmo_expired_detect", detect_add, 1'b1);
`else
    for (int i = 30; i < 40; i++) step("tmo_still_waiting");
    check_bit("tmo_none_detect", detect_add, 1'b0);
    soft_reset_0 = 1;
    step("tmo_soft_exit");
    soft_reset_0 = 0;
`endif
    fifo_empty_0 = 1;

    // Mid-packet reset
    pkt_valid = 1; data_in = 2;
    step("mid_lfd");
    step("mid_ld");
    reset = 1;
    step("mid_reset");
    check_bit("mid_reset_detect", detect_add, 1'b1);
    reset = 0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 199) == 0);
      pkt_valid     = ($urandom_range(0, 3) != 0);
      data_in       = 2'($urandom_range(0, 3));
      fifo_empty_0  = ($urandom_range(0, 3) != 0);
      fifo_empty_1  = ($urandom_range(0, 3) != 0);
      fifo_empty_2  = ($urandom_range(0, 3) != 0);
      soft_reset_0  = ($urandom_range(0, 39) == 0);
      soft_reset_1  = ($urandom_range(0, 39) == 0);
      soft_reset_2  = ($urandom_range(0, 39) == 0);
      fifo_full     = ($urandom_range(0, 3) == 0);
      parity_done   = ($urandom_range(0, 7) == 0);
      low_pkt_valid = ($urandom_range(0, 3) == 0);
      step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 SHALL have port: clock  in  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: pkt_valid  in  1  source asserts for header through last payload byte.
REQ-004 SHALL have port: data_in  in  2  header address bits [1:0]; 0..2 valid, 3 invalid.
REQ-005 SHALL have ports: fifo_empty_0/1/2  in  1 each  per-output FIFO empty.
REQ-006 SHALL have ports: soft_reset_0/1/2  in  1 each  per-output synchronizer timeout.
REQ-007 SHALL have ports: fifo_full  in  1 (addressed FIFO full); parity_done  in  1; low_pkt_valid  in  1.
REQ-008 SHALL have outputs, 1 bit each: detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy.

Function
REQ-009 SHALL implement states DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
REQ-010 SHALL latch data_in into a 2-bit addr register on every cycle in DECODE_ADDRESS with pkt_valid=1.
REQ-011 DECODE_ADDRESS: pkt_valid & data_in<3 & fifo_empty_[data_in] -> LOAD_FIRST_DATA; pkt_valid & data_in<3 & !fifo_empty_[data_in] -> WAIT_TILL_EMPTY; else stay.
REQ-012 Header with data_in=3 SHALL be ignored: stay in DECODE_ADDRESS, no write enables.
REQ-013 LOAD_FIRST_DATA -> LOAD_DATA unconditionally (exactly one cycle).
REQ-014 LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
REQ-015 FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
REQ-016 LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else LOAD_DATA.
REQ-017 LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
REQ-018 CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else DECODE_ADDRESS.
REQ-019 WAIT_TILL_EMPTY: fifo_empty_[addr] -> LOAD_FIRST_DATA; else stay.
REQ-020 soft_reset_[addr]=1 in any state other than DECODE_ADDRESS SHALL force DECODE_ADDRESS next cycle, overriding REQ-013..019; soft resets of non-addressed ports SHALL be ignored.
REQ-021 Outputs SHALL be Moore, decoded from current state only: detect_add=DECODE_ADDRESS; lfd_state=LOAD_FIRST_DATA; ld_state=LOAD_DATA; laf_state=LOAD_AFTER_FULL; full_state=FIFO_FULL_STATE; rst_int_reg=CHECK_PARITY_ERROR.
REQ-022 write_enb_reg SHALL be 1 in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL; 0 elsewhere.
REQ-023 busy SHALL be 1 in every state except DECODE_ADDRESS and LOAD_DATA.
REQ-024 Output latency SHALL be zero cycles from state register; state change one cycle after qualifying inputs.

Reset
REQ-025 reset=1 at a rising edge SHALL set state=DECODE_ADDRESS, addr=0, timeout counter=0, from any state incl. mid-packet.
REQ-026 While reset applies, outputs SHALL be detect_add=1, all other outputs 0.
REQ-027 reset SHALL take priority over soft_reset and all transitions.

Configuration
REQ-028 Macro ROUTER_FSM_WAIT_TIMEOUT_EN SHALL control a WAIT_TILL_EMPTY timeout.
REQ-029 Defined: 5-bit counter, cleared on WAIT_TILL_EMPTY entry, increments each cycle there; at count 29 with fifo_empty_[addr]=0, next state DECODE_ADDRESS (30 cycles total wait); empty at same cycle wins -> LOAD_FIRST_DATA.
REQ-030 Undefined: no counter; WAIT_TILL_EMPTY exits only via REQ-019, REQ-020 or reset.

Verification
REQ-031 Reset then pkt_valid=1, data_in=2, fifo_empty_2=1 -> LOAD_FIRST_DATA next cycle (lfd_state=1, busy=1), then LOAD_DATA (write_enb_reg=1, busy=0).
REQ-032 In LOAD_DATA pkt_valid=0 -> LOAD_PARITY (write_enb_reg=1, busy=1) -> CHECK_PARITY_ERROR (rst_int_reg=1) -> DECODE_ADDRESS with fifo_full=0.
REQ-033 In LOAD_DATA fifo_full=1 for 3 cycles -> full_state=1 for 3 cycles, write_enb_reg=0; release with low_pkt_valid=1 -> LOAD_AFTER_FULL then LOAD_PARITY.
REQ-034 data_in=1, fifo_empty_1=0 -> WAIT_TILL_EMPTY; soft_reset_0=1 ignored; soft_reset_1=1 -> DECODE_ADDRESS next cycle.
REQ-035 data_in=3, pkt_valid=1 for 5 cycles -> detect_add stays 1, write_enb_reg stays 0.
REQ-036 With ROUTER_FSM_WAIT_TIMEOUT_EN, fifo_empty_0 held 0 after data_in=0 header -> DECODE_ADDRESS exactly 30 cycles after WAIT_TILL_EMPTY entry; without macro, still WAIT_TILL_EMPTY at cycle 40.
